// File: rtl/ram_access_controller.sv
// ram_access_controller: sole master of a single-port RAM.
// After reset (or a clear pulse) it writes INIT_VALUE to every location.
// It then serves one read or write request per cycle.
// Read data comes back on rsp_valid two edges after the request is accepted.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on the FSM state and the
// clear input, never on req_valid, so there is no combinational loop back
// to the requester. While req_valid is high and req_ready is low, the
// requester must hold req_we, req_addr and req_wdata stable.
module ram_access_controller #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            fill_last;
    logic            accept;
    logic            p1, p2;

    // The counter is one bit wider than the address.
    // The sweep ends on DEPTH-1, so only the low bits ever reach the RAM pins.
    assign fill_last = (cnt == CW'(DEPTH - 1));
    assign req_ready = (state == RUN) & ~clear;
    assign accept    = req_valid & req_ready;

    // Next state and next fill counter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            INIT: begin
                if (clear) begin
                    cnt_next = '0;
                end else if (fill_last) begin
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RUN: begin
                if (clear) begin
                    cnt_next   = '0;
                    state_next = INIT;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = INIT;
            end
        endcase
    end

    // State, fill counter and init_done registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            init_done <= (state_next == RUN);
        end
    end

    // RAM pin registers: fill writes in INIT, accepted requests in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else if ((state == INIT) && !clear) begin
            ram_we   <= 1'b1;
            ram_addr <= cnt[ADDR_WIDTH-1:0];
            ram_data <= INIT_VALUE;
        end else if (accept) begin
            ram_we   <= req_we;
            ram_addr <= req_addr;
            ram_data <= req_we ? req_wdata : '0;
        end else begin
            ram_we   <= 1'b0;
        end
    end

    // Read pipeline: the RAM registers the address one edge after we drive it.
    // Its q output is captured on the edge after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1        <= 1'b0;
            p2        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            p1        <= accept & ~req_we;
            p2        <= p1;
            rsp_valid <= p2;
            if (p2) begin
                rsp_data <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_controller.sv
// Directed bench for ram_access_controller with a behavioural single-port RAM.
module tb_ram_access_controller;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       init_done;
    logic [7:0] ram_data;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_q;

    int checks = 0;
    int errors = 0;

    ram_access_controller #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(6),
        .INIT_VALUE(8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    // Single-port RAM: registered address, write committed on the edge.
    logic [7:0] mem [0:63];
    logic [5:0] addr_r;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        addr_r <= ram_addr;
    end
    assign ram_q = mem[addr_r];

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then check the response strobe.
    task automatic step(input logic v, input logic we, input logic [5:0] a,
                        input logic [7:0] d, input logic exp_rv,
                        input logic [7:0] exp_rd, input string tag);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        tick();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_rd));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ram_we"},    32'(ram_we),    32'(0));
        chk({tag, "_ram_addr"},  32'(ram_addr),  32'(0));
        chk({tag, "_ram_data"},  32'(ram_data),  32'(0));
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'(0));
        chk({tag, "_init_done"}, 32'(init_done), 32'(0));
        chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        req_valid = 1'b1;    // held high through the sweep: must not be accepted
        req_we    = 1'b0;
        req_addr  = 6'd63;
        req_wdata = 8'h00;
        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_before_edge1", 32'(req_ready), 32'(0));

        // Fill sweep: edge i+1 issues address i.
        for (int i = 0; i < 64; i++) begin
            tick();
            chk($sformatf("sweep_we_%0d", i),   32'(ram_we),   32'(1));
            chk($sformatf("sweep_addr_%0d", i), 32'(ram_addr), 32'(i));
            chk($sformatf("sweep_data_%0d", i), 32'(ram_data), 32'(0));
            chk($sformatf("sweep_done_%0d", i), 32'(init_done), 32'(i == 63));
            chk($sformatf("sweep_ready_%0d", i), 32'(req_ready), 32'(i == 63));
        end

        // Reads of 63, 0, 1 after the sweep; the first is accepted at edge 65.
        step(1, 0, 6'd63, 8'h00, 0, 8'h00, "rd63");
        chk("rd63_ram_addr", 32'(ram_addr), 32'(63));
        chk("rd63_ram_we",   32'(ram_we),   32'(0));
        step(1, 0, 6'd0,  8'h00, 0, 8'h00, "rd0");
        step(1, 0, 6'd1,  8'h00, 1, 8'h00, "rd1");
        // Back-to-back writes; the responses for 0 and 1 come out meanwhile.
        step(1, 1, 6'd0,  8'hF0, 1, 8'h00, "wr0");
        chk("wr0_ram_we",   32'(ram_we),   32'(1));
        chk("wr0_ram_addr", 32'(ram_addr), 32'(0));
        chk("wr0_ram_data", 32'(ram_data), 32'hF0);
        step(1, 1, 6'd1,  8'hE1, 1, 8'h00, "wr1");
        step(1, 1, 6'd2,  8'hD2, 0, 8'h00, "wr2");
        chk("wr2_ram_data", 32'(ram_data), 32'hD2);
        // Back-to-back reads of 0, 1, 2.
        step(1, 0, 6'd0,  8'h55, 0, 8'h00, "rb0");
        chk("rb0_ram_data", 32'(ram_data), 32'h00);
        chk("rb0_ram_we",   32'(ram_we),   32'(0));
        step(1, 0, 6'd1,  8'h00, 0, 8'h00, "rb1");
        step(1, 0, 6'd2,  8'h00, 1, 8'hF0, "rb2");
        step(0, 0, 6'd0,  8'h00, 1, 8'hE1, "rb_idle1");
        step(0, 0, 6'd0,  8'h00, 1, 8'hD2, "rb_idle2");
        step(0, 0, 6'd0,  8'h00, 0, 8'h00, "rb_idle3");
        chk("idle_ram_we", 32'(ram_we), 32'(0));

        // Read-after-write on consecutive cycles.
        step(1, 1, 6'd10, 8'hA5, 0, 8'h00, "raw_wr");
        step(1, 0, 6'd10, 8'h00, 0, 8'h00, "raw_rd");
        step(0, 0, 6'd0,  8'h00, 0, 8'h00, "raw_gap");
        step(0, 0, 6'd0,  8'h00, 1, 8'hA5, "raw_rsp");
        step(0, 0, 6'd0,  8'h00, 0, 8'h00, "raw_after");
        chk("raw_hold_data", 32'(rsp_data), 32'hA5);

        // clear with a read in flight; the request presented with clear is dropped.
        step(1, 0, 6'd2, 8'h00, 0, 8'h00, "clr_rd");
        clear     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 6'd5;
        req_wdata = 8'h77;
        #1;
        chk("clr_ready", 32'(req_ready), 32'(0));
        tick();
        clear = 1'b0;
        chk("clr_no_accept_we", 32'(ram_we),    32'(0));
        chk("clr_addr_hold",    32'(ram_addr),  32'(2));
        chk("clr_init_done",    32'(init_done), 32'(0));
        chk("clr_ready_init",   32'(req_ready), 32'(0));
        chk("clr_rsp_valid0",   32'(rsp_valid), 32'(0));
        for (int k = 0; k < 64; k++) begin
            tick();
            chk($sformatf("clr_sweep_we_%0d", k),   32'(ram_we),   32'(1));
            chk($sformatf("clr_sweep_addr_%0d", k), 32'(ram_addr), 32'(k));
            if (k == 0) begin
                chk("clr_pending_rsp_valid", 32'(rsp_valid), 32'(1));
                chk("clr_pending_rsp_data",  32'(rsp_data),  32'hD2);
            end
        end
        chk("clr_sweep_done", 32'(init_done), 32'(1));
        step(1, 0, 6'd0,  8'h00, 0, 8'h00, "cr0");
        step(1, 0, 6'd1,  8'h00, 0, 8'h00, "cr1");
        step(1, 0, 6'd2,  8'h00, 1, 8'h00, "cr2");
        step(1, 0, 6'd10, 8'h00, 1, 8'h00, "cr10");
        step(1, 0, 6'd5,  8'h00, 1, 8'h00, "cr5");
        step(0, 0, 6'd0,  8'h00, 1, 8'h00, "cr_idle1");
        step(0, 0, 6'd0,  8'h00, 1, 8'h00, "cr_idle2");
        step(0, 0, 6'd0,  8'h00, 0, 8'h00, "cr_idle3");

        // Reset while a read sits in the first pipeline stage.
        step(1, 0, 6'd10, 8'h00, 0, 8'h00, "rst_rd");
        req_valid = 1'b0;
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        tick();
        chk("midrst_rsp_valid_edge", 32'(rsp_valid), 32'(0));
        chk("midrst_ram_we_edge",    32'(ram_we),    32'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("restart_we0",   32'(ram_we),    32'(1));
        chk("restart_addr0", 32'(ram_addr),  32'(0));
        chk("restart_rsp0",  32'(rsp_valid), 32'(0));
        tick();
        chk("restart_addr1", 32'(ram_addr),  32'(1));
        chk("restart_rsp1",  32'(rsp_valid), 32'(0));
        chk("restart_done",  32'(init_done), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
